// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with 3-sample majority vote
// Frame: start(0), DATA_WIDTH bits LSB first, optional parity, stop(1).
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  rx_busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int M  = PRESCALE / 2;

    localparam logic [CW-1:0] EC_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] EC_S0   = CW'(M - 1);
    localparam logic [CW-1:0] EC_S1   = CW'(M);
    localparam logic [CW-1:0] EC_S2   = CW'(M + 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [2:0]              smp_q, smp_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic                    par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q, stop_error_d;

    logic bit_end;
    logic smp2;
    logic bit_val;
    logic stp_err;

    // The third sample is taken from the live line when bit end coincides with it (PRESCALE=4).
    assign bit_end = (edge_cnt_q == EC_LAST);
    assign smp2    = (edge_cnt_q == EC_S2) ? rx_in : smp_q[2];
    assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp2) | (smp_q[1] & smp2);
    assign stp_err = ~bit_val;

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        smp_d          = smp_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        par_err_d      = par_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        if (state_q == S_IDLE) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + 1'b1;
            if (edge_cnt_q == EC_S0) smp_d[0] = rx_in;
            if (edge_cnt_q == EC_S1) smp_d[1] = rx_in;
            if (edge_cnt_q == EC_S2) smp_d[2] = rx_in;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_in) begin
                    state_d    = S_START;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                    par_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    if (bit_val) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BC_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_err_d = (bit_val != ((^shift_q) ^ par_type_q));
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!par_err_q && !stp_err) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end else begin
                        parity_error_d = par_err_q;
                        stop_error_d   = stp_err;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            smp_q          <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_err_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            smp_q          <= smp_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            par_err_q      <= par_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;

    localparam int DW = 8;
    localparam int PS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic          parity_en = 1'b0;
    logic          parity_type = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          rx_busy;

    uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cycles = 0;
    int dv_cyc = 0, dv_prev_cyc = 0, dv_last = 0, dv_prev = 0;

    // Strobe-high cycles are counted, so a strobe longer than one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt      = dv_cnt + 1;
            dv_prev     = dv_last;
            dv_last     = int'(p_data);
            dv_prev_cyc = dv_cyc;
            dv_cyc      = cyc;
        end
        if (parity_error) pe_cnt = pe_cnt + 1;
        if (stop_error)   se_cnt = se_cnt + 1;
        if (rx_busy)      busy_cycles = busy_cycles + 1;
    end

    int total = 0, bad = 0;
    int start_cyc = 0;
    int b0;

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        step(n);
    endtask

    // Drives one frame cycle by cycle; parity inputs are flipped mid-frame to prove they were latched.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic par_bit, input logic stop_bit,
                              input int spike_k, input int abort_k);
        logic bits [0:10];
        int   nb;
        nb = pe ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = pe ? par_bit : stop_bit;
        bits[10] = stop_bit;
        parity_en   = pe;
        parity_type = pt;
        start_cyc   = cyc;
        for (int k = 0; k < nb * PS; k++) begin
            if (k == abort_k) begin
                rst   = 1'b1;
                rx_in = 1'b1;
                step(1);
                rst         = 1'b0;
                parity_en   = pe;
                parity_type = pt;
                return;
            end
            rx_in = bits[k / PS] ^ (k == spike_k);
            if (k == 20) begin
                parity_en   = ~pe;
                parity_type = ~pt;
            end
            step(1);
        end
        parity_en   = pe;
        parity_type = pt;
        rx_in       = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        idle(200);
        chk("rst_p_data", int'(p_data), 0);
        chk("rst_dv_cnt", dv_cnt, 0);
        chk("rst_pe_cnt", pe_cnt, 0);
        chk("rst_se_cnt", se_cnt, 0);
        chk("rst_busy",   int'(rx_busy), 0);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(5);
        chk("a5_dv_cnt",  dv_cnt, 1);
        chk("a5_latency", dv_cyc, start_cyc + 81);
        chk("a5_p_data",  int'(p_data), 'hA5);
        chk("a5_pe_cnt",  pe_cnt, 0);
        chk("a5_se_cnt",  se_cnt, 0);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(5);
        chk("par_ok_dv_cnt",  dv_cnt, 2);
        chk("par_ok_latency", dv_cyc, start_cyc + 89);
        chk("par_ok_p_data",  int'(p_data), 'h3C);
        chk("par_ok_pe_cnt",  pe_cnt, 0);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(5);
        chk("par_bad_pe_cnt", pe_cnt, 1);
        chk("par_bad_dv_cnt", dv_cnt, 2);
        chk("par_bad_se_cnt", se_cnt, 0);
        chk("par_bad_p_data", int'(p_data), 'h3C);

        b0 = busy_cycles;
        rx_in = 1'b0;
        step(2);
        idle(30);
        chk("glitch_busy_len", busy_cycles - b0, PS);
        chk("glitch_busy",     int'(rx_busy), 0);
        chk("glitch_dv_cnt",   dv_cnt, 2);
        chk("glitch_pe_cnt",   pe_cnt, 1);
        chk("glitch_se_cnt",   se_cnt, 0);

        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(5);
        chk("stop_se_cnt", se_cnt, 1);
        chk("stop_dv_cnt", dv_cnt, 2);
        chk("stop_p_data", int'(p_data), 'h3C);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(10);
        chk("b2b_dv_cnt", dv_cnt, 4);
        chk("b2b_first",  dv_prev, 'h55);
        chk("b2b_second", dv_last, 'hAA);
        chk("b2b_gap",    dv_cyc - dv_prev_cyc, 81);
        chk("b2b_se_cnt", se_cnt, 1);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 37, -1);
        idle(5);
        chk("spike_dv_cnt", dv_cnt, 5);
        chk("spike_p_data", int'(p_data), 'hA5);

        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, 40);
        chk("abort_busy",   int'(rx_busy), 0);
        chk("abort_p_data", int'(p_data), 0);
        idle(100);
        chk("abort_dv_cnt", dv_cnt, 5);
        chk("abort_se_cnt", se_cnt, 1);
        chk("abort_pe_cnt", pe_cnt, 1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(5);
        chk("post_abort_dv_cnt",  dv_cnt, 6);
        chk("post_abort_p_data",  int'(p_data), 'h5A);
        chk("post_abort_latency", dv_cyc, start_cyc + 81);

        rx_in = 1'b0;
        step(162);
        idle(20);
        chk("break_se_cnt", se_cnt, 3);
        chk("break_dv_cnt", dv_cnt, 6);
        chk("break_p_data", int'(p_data), 'h5A);
        chk("break_busy",   int'(rx_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
